// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment digit scanner.
package seven_seg_pkg;
   localparam int NUM_DIGITS_DEF = 6;
   localparam int DIG_IDX_W      = $clog2(NUM_DIGITS_DEF);

   typedef logic [DIG_IDX_W-1:0] dig_idx_t;
   typedef logic [3:0]           bcd_t;

   localparam logic [NUM_DIGITS_DEF-1:0] DIG_OFF_N = '1;
endpackage

// File: rtl/scan_prescaler.sv
// Slot-rate divider: div_cnt runs 0..SCAN_DIV-1 while en is high.
module scan_prescaler #(
   parameter int SCAN_DIV = 50000,
   parameter int DW       = $clog2(SCAN_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [DW-1:0] div_cnt,
   output logic          slot_end
);
   assign slot_end = en && (div_cnt == DW'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        div_cnt <= '0;
      else if (slot_end) div_cnt <= '0;
      else if (en)       div_cnt <= div_cnt + 1'b1;
   end
endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed BCD digit scanner feeding a 7-segment decoder.
// Optional: define LEADING_ZERO_BLANK_EN to blank a leading zero digit.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits_bcd,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [3:0]              val,
   output logic [NUM_DIGITS-1:0]   dig_sel_n,
   output logic                    dp_n,
   output logic                    frame_start
);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [NUM_DIGITS-1:0] OFF_N = '1;

   logic [DW-1:0]             div_cnt;
   logic                      slot_end;
   logic [IW-1:0]             idx;
   logic [4*NUM_DIGITS-1:0]   snapshot;
   logic [NUM_DIGITS-1:0]     dp_snap;
   logic                      snap_now;
   logic [4*NUM_DIGITS-1:0]   snap_eff;
   logic [NUM_DIGITS-1:0]     dp_eff;
   bcd_t                      cur_val;
   logic                      dig_on;

   scan_prescaler #(.SCAN_DIV(SCAN_DIV), .DW(DW)) u_pre (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .div_cnt  (div_cnt),
      .slot_end (slot_end)
   );

   assign snap_now = en && (div_cnt == '0) && (idx == '0);

   // Forward the incoming word on the load cycle so slot 0 of a new frame
   // never shows a stale digit from the previous frame.
   assign snap_eff = snap_now ? digits_bcd : snapshot;
   assign dp_eff   = snap_now ? dp_in      : dp_snap;
   assign cur_val  = snap_eff[4*int'(idx) +: 4];

   always_comb begin
      dig_on = (int'(div_cnt) >= BLANK_CYCLES);
`ifdef LEADING_ZERO_BLANK_EN
      if (int'(idx) == NUM_DIGITS - 1 && snap_eff[4*NUM_DIGITS-1 -: 4] == 4'd0)
         dig_on = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         snapshot    <= '0;
         dp_snap     <= '0;
         val         <= '0;
         dig_sel_n   <= OFF_N;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= snap_now;
         if (snap_now) begin
            snapshot <= digits_bcd;
            dp_snap  <= dp_in;
         end
         if (slot_end)
            idx <= (int'(idx) == NUM_DIGITS - 1) ? '0 : idx + 1'b1;
         if (en) begin
            val       <= cur_val;
            dig_sel_n <= dig_on ? ~(NUM_DIGITS'(1) << idx) : OFF_N;
            dp_n      <= dig_on ? ~dp_eff[idx] : 1'b1;
         end else begin
            dig_sel_n <= OFF_N;
            dp_n      <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized self-checking bench for seven_seg_scan against a frame-position model.
module tb_seven_seg_scan;
   localparam int N  = 6;
   localparam int SD = 4;
   localparam int BL = 1;
   localparam int FRAME = N * SD;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic [4*N-1:0]  digits_bcd = '0;
   logic [N-1:0]    dp_in = '0;
   logic [3:0]      val;
   logic [N-1:0]    dig_sel_n;
   logic            dp_n;
   logic            frame_start;

   int n_chk = 0;
   int n_fail = 0;

   // model state: position within the frame as elapsed enabled cycles
   int              pos = 0;
   int              m_dig[N];
   bit [N-1:0]      m_dp = '0;
   int              e_val = 0;
   bit [N-1:0]      e_sel = '1;
   bit              e_dp = 1'b1;
   bit              e_fs = 1'b0;

   seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .digits_bcd(digits_bcd), .dp_in(dp_in),
      .val(val), .dig_sel_n(dig_sel_n), .dp_n(dp_n), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos = 0; m_dp = '0; e_val = 0; e_sel = '1; e_dp = 1'b1; e_fs = 1'b0;
      for (int i = 0; i < N; i++) m_dig[i] = 0;
   endtask

   task automatic model_step(input bit e, input logic [4*N-1:0] d, input logic [N-1:0] p);
      int slot, ph;
      bit lit;
      e_fs = e && (pos == 0);
      if (e_fs) begin
         for (int i = 0; i < N; i++) m_dig[i] = int'(d[4*i +: 4]);
         m_dp = p;
      end
      if (e) begin
         slot = pos / SD;
         ph   = pos % SD;
         lit  = (ph >= BL);
`ifdef LEADING_ZERO_BLANK_EN
         if (slot == N - 1 && m_dig[N-1] == 0) lit = 1'b0;
`endif
         e_val = m_dig[slot];
         e_sel = lit ? ~(N'(1) << slot) : '1;
         e_dp  = lit ? ~m_dp[slot] : 1'b1;
         pos   = (pos + 1) % FRAME;
      end else begin
         e_sel = '1;
         e_dp  = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".val"}, int'(val), e_val);
      check({tag, ".sel"}, int'(dig_sel_n), int'(e_sel));
      check({tag, ".dp"}, int'(dp_n), int'(e_dp));
      check({tag, ".fs"}, int'(frame_start), int'(e_fs));
      check({tag, ".onehot"}, int'($countones(~dig_sel_n) <= 1), 1);
   endtask

   task automatic cyc(input string tag, input bit e, input logic [4*N-1:0] d,
                      input logic [N-1:0] p);
      en = e; digits_bcd = d; dp_in = p;
      @(posedge clk);
      if (rst_n) model_step(e, d, p);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [4*N-1:0] d;
      logic [N-1:0]   p;
      int fs_cnt;
      model_reset();
      #23;
      check_outputs("reset");
      rst_n = 1'b1;

      // basic scan of a full frame, counting frame_start pulses
      fs_cnt = 0;
      for (int c = 0; c < FRAME; c++) begin
         cyc("basic", 1'b1, 24'h123456, '0);
         fs_cnt += int'(frame_start);
      end
      check("basic.fs_count", fs_cnt, 1);

      // snapshot isolation: new word arrives during slot 2
      for (int c = 0; c < 2 * SD; c++) cyc("iso_a", 1'b1, 24'h123456, '0);
      for (int c = 0; c < FRAME + SD; c++) cyc("iso_b", 1'b1, 24'h999999, '0);

      // decimal points on digits 2 and 4, then en gap mid-slot
      for (int c = 0; c < FRAME + 2; c++) cyc("dp", 1'b1, 24'h999999, 6'b010100);
      for (int c = 0; c < 10; c++) cyc("en_off", 1'b0, 24'h999999, 6'b010100);
      for (int c = 0; c < FRAME; c++) cyc("en_on", 1'b1, 24'h999999, 6'b010100);

      // async reset mid-frame, between edges
      while (pos != 3 * SD + 2) cyc("pre_rst", 1'b1, 24'h654321, 6'b000001);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs("async_rst");
      @(posedge clk); #1 check_outputs("rst_hold");
      #3 rst_n = 1'b1;
      for (int c = 0; c < FRAME; c++) cyc("post_rst", 1'b1, 24'h090500, 6'b000010);

      // random traffic with an occasional mid-run reset
      d = 24'h012345; p = '0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) d = 24'($urandom());
         if ($urandom_range(0, 3) == 0) d[4*N-1 -: 4] = 4'd0;
         if ($urandom_range(0, 7) == 0) p = N'($urandom());
         if (c == 700) begin
            #($urandom_range(1, 7)) rst_n = 1'b0;
            #1 model_reset();
            check_outputs("rnd_rst");
            @(posedge clk); #2 rst_n = 1'b1;
         end
         cyc("rnd", ($urandom_range(0, 9) != 0), d, p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
